// File: rtl/ib_pkg.sv
// ib_pkg: shared types and constants for the instruction-bus responder
// Provides the 2-bit FSM state encoding, the bus data width and the NOP
// returned for out-of-range fetches.
package ib_pkg;
    localparam int IB_DATA_W = 32;
    localparam logic [IB_DATA_W-1:0] RV_NOP = 32'h0000_0013;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} ib_state_e;
endpackage

// File: rtl/ib_sram16_responder.sv
// ib_sram16_responder: serves 32-bit instruction words from a 16-bit async SRAM/flash
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ib_addr, ib_valid   fetch request (byte address, bits [1:0] ignored)
//   ib_ready, ib_din    one-cycle completion strobe and instruction word
//   mem_addr            external halfword address
//   mem_ce_n, mem_oe_n  external chip/output enables, active-low
//   mem_din             external read data, little-endian halfwords
module ib_sram16_responder
    import ib_pkg::*;
#(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] ROM_BYTES   = 32'h0010_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          ib_addr,
    input  logic                 ib_valid,
    output logic                 ib_ready,
    output logic [IB_DATA_W-1:0] ib_din,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_ce_n,
    output logic                 mem_oe_n,
    input  logic [15:0]          mem_din
);
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    ib_state_e            state_q;
    logic [ADDR_W-2:0]    a_q;
    logic [3:0]           cnt_q;
    logic [IB_DATA_W-1:0] data_q;
    // The strobe follows ib_valid so a late re-request still completes in DONE.
    assign ib_ready = (state_q == DONE) && ib_valid;
    assign ib_din   = data_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            cnt_q    <= 4'd0;
            data_q   <= '0;
            mem_addr <= '0;
            mem_ce_n <= 1'b1;
            mem_oe_n <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (ib_valid) begin
                    if (ib_addr < ROM_BYTES) begin
                        a_q      <= ib_addr[ADDR_W:2];
                        cnt_q    <= WS;
                        mem_addr <= {ib_addr[ADDR_W:2], 1'b0};
                        mem_ce_n <= 1'b0;
                        mem_oe_n <= 1'b0;
                        state_q  <= LO;
                    end else begin
                        data_q  <= RV_NOP;
                        state_q <= DONE;
                    end
                end
                // The address has been held for WAIT_STATES+1 cycles when the count hits 0.
                LO: if (cnt_q == 4'd0) begin
                    data_q[15:0] <= mem_din;
                    cnt_q        <= WS;
                    mem_addr     <= {a_q, 1'b1};
                    state_q      <= HI;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                HI: if (cnt_q == 4'd0) begin
                    data_q[31:16] <= mem_din;
                    mem_ce_n      <= 1'b1;
                    mem_oe_n      <= 1'b1;
                    state_q       <= DONE;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                DONE: if (ib_valid) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
